// File: rtl/fma_line_memory.sv
// fma_line_memory: line-organised operand cache for the FMA array; stages words or buffer
// lines into a single-port BRAM and returns lines as packed a/b/c operands.
// Optional feature macro FMA_LINE_MEMORY_AUTO_INCR_EN: addr advances after each write / read handshake.
//
// state   | meaning
// IDLE    | accepting instructions
// BUFWAIT | LDBUF accepted, waiting for buffer_valid_in
// WRITE   | BRAM write of wr_line_q at addr
// RD1     | BRAM read issued
// RD2     | BRAM output register -> abc register
// OUT     | abc_valid_out high until abc_ready_in
module fma_line_memory #(
  parameter int FMA_COUNT         = 2,
  parameter int WORD_WIDTH        = 16,
  parameter int LINE_WIDTH        = 3*FMA_COUNT*WORD_WIDTH,
  parameter int DEPTH             = 375,
  parameter int ADDR_WIDTH        = $clog2(DEPTH),
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  input  logic [LINE_WIDTH-1:0]        buffer_read_in,
  input  logic                         buffer_valid_in,
  output logic                         buffer_ack_out,
  output logic [LINE_WIDTH-1:0]        abc_out,
  output logic                         abc_valid_out,
  input  logic                         abc_ready_in,
  output logic                         idle_out,
  output logic [2:0]                   error_out
);

  localparam int W = 3*FMA_COUNT;

  localparam logic [3:0] OP_SETADDR = 4'b1000;
  localparam logic [3:0] OP_LDIMM   = 4'b1001;
  localparam logic [3:0] OP_LDBUF   = 4'b1010;
  localparam logic [3:0] OP_COMMIT  = 4'b1011;
  localparam logic [3:0] OP_READ    = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE, S_BUFWAIT, S_WRITE, S_RD1, S_RD2, S_OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_WIDTH-1:0]   stage_q [W];
  logic [WORD_WIDTH-1:0]   stage_d [W];
  logic [W-1:0]            mask_q, mask_d;
  logic [LINE_WIDTH-1:0]   wr_line_q, wr_line_d;
  logic [LINE_WIDTH-1:0]   abc_q, abc_d;
  logic [2:0]              err_q, err_d;

  logic [LINE_WIDTH-1:0]   mem [DEPTH];
  logic [LINE_WIDTH-1:0]   bram_rd_q;
  logic                    bram_we;
  logic                    bram_re;

  logic [3:0]              opcode;
  logic [3:0]              slot;
  logic [15:0]             imm;
  logic [LINE_WIDTH-1:0]   stage_line;
  logic                    unused_instr_bits;

  assign opcode            = instr_in[31:28];
  assign slot              = instr_in[27:24];
  assign imm               = instr_in[23:8];
  assign unused_instr_bits = ^instr_in[7:0];

  // Slot 0 lands in the MSBs of the line.
  always_comb begin
    stage_line = '0;
    for (int k = 0; k < W; k++) begin
      stage_line[LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = stage_q[k];
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    stage_d         = stage_q;
    mask_d          = mask_q;
    wr_line_d       = wr_line_q;
    abc_d           = abc_q;
    err_d           = err_q;
    instr_ready_out = 1'b0;
    buffer_ack_out  = 1'b0;
    abc_valid_out   = 1'b0;
    bram_we         = 1'b0;
    bram_re         = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready_out = 1'b1;
        if (instr_valid_in) begin
          case (opcode)
            OP_SETADDR: begin
              if (32'(imm) >= DEPTH) err_d[2] = 1'b1;
              else                   addr_d   = imm[ADDR_WIDTH-1:0];
            end
            OP_LDIMM: begin
              if (32'(slot) >= W) begin
                err_d[1] = 1'b1;
              end else begin
                for (int k = 0; k < W; k++) begin
                  if (32'(slot) == k) begin
                    stage_d[k] = imm[WORD_WIDTH-1:0];
                    mask_d[k]  = 1'b1;
                  end
                end
              end
            end
            OP_COMMIT: begin
              // An incomplete line is refused but its mask is kept for completion.
              if (&mask_q) begin
                wr_line_d = stage_line;
                mask_d    = '0;
                state_d   = S_WRITE;
              end else begin
                err_d[1] = 1'b1;
              end
            end
            OP_LDBUF: state_d  = S_BUFWAIT;
            OP_READ:  state_d  = S_RD1;
            default:  err_d[0] = 1'b1;
          endcase
        end
      end
      S_BUFWAIT: begin
        if (buffer_valid_in) begin
          buffer_ack_out = 1'b1;
          wr_line_d      = buffer_read_in;
          state_d        = S_WRITE;
        end
      end
      S_WRITE: begin
        bram_we = 1'b1;
        state_d = S_IDLE;
`ifdef FMA_LINE_MEMORY_AUTO_INCR_EN
        addr_d  = (addr_q == ADDR_WIDTH'(DEPTH-1)) ? '0 : addr_q + 1'b1;
`endif
      end
      S_RD1: begin
        bram_re = 1'b1;
        state_d = S_RD2;
      end
      S_RD2: begin
        abc_d   = bram_rd_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        abc_valid_out = 1'b1;
        if (abc_ready_in) begin
          state_d = S_IDLE;
`ifdef FMA_LINE_MEMORY_AUTO_INCR_EN
          addr_d  = (addr_q == ADDR_WIDTH'(DEPTH-1)) ? '0 : addr_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign idle_out  = instr_ready_out;
  assign abc_out   = abc_q;
  assign error_out = err_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      wr_line_q <= '0;
      abc_q     <= '0;
      err_q     <= '0;
      for (int k = 0; k < W; k++) stage_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      wr_line_q <= wr_line_d;
      abc_q     <= abc_d;
      err_q     <= err_d;
      stage_q   <= stage_d;
    end
  end

  // BRAM contents survive reset; only one of write/read is ever active.
  always_ff @(posedge clk_in) begin
    if (bram_we) begin
      mem[addr_q] <= wr_line_q;
    end else if (bram_re) begin
      bram_rd_q <= mem[addr_q];
    end
  end

endmodule

// File: tb/tb_fma_line_memory.sv
// Self-checking bench for fma_line_memory: directed plan steps followed by random
// instruction traffic checked against an array-based reference model.
module tb_fma_line_memory;
  localparam int W     = 6;
  localparam int LW    = 96;
  localparam int DEPTH = 375;
  localparam int IW    = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [IW-1:0] instr_in;
  logic          instr_valid_in;
  logic          instr_ready_out;
  logic [LW-1:0] buffer_read_in;
  logic          buffer_valid_in;
  logic          buffer_ack_out;
  logic [LW-1:0] abc_out;
  logic          abc_valid_out;
  logic          abc_ready_in;
  logic          idle_out;
  logic [2:0]    error_out;

  fma_line_memory dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .instr_in        (instr_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .buffer_read_in  (buffer_read_in),
    .buffer_valid_in (buffer_valid_in),
    .buffer_ack_out  (buffer_ack_out),
    .abc_out         (abc_out),
    .abc_valid_out   (abc_valid_out),
    .abc_ready_in    (abc_ready_in),
    .idle_out        (idle_out),
    .error_out       (error_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [LW-1:0] m_mem [DEPTH];
  bit            m_written [DEPTH];
  int            m_addr;
  logic [15:0]   m_stage [W];
  bit            m_mask [W];
  logic [2:0]    m_err;
  logic [LW-1:0] m_abc;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] line = '0;
    for (int k = 0; k < W; k++) line = (line << 16) | LW'(m_stage[k]);
    return line;
  endfunction

  function automatic bit model_full();
    for (int k = 0; k < W; k++) if (!m_mask[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_advance();
`ifdef FMA_LINE_MEMORY_AUTO_INCR_EN
    m_addr = (m_addr + 1) % DEPTH;
`endif
  endfunction

  function automatic void model_reset();
    m_addr = 0;
    m_err  = 3'b000;
    m_abc  = '0;
    for (int k = 0; k < W; k++) begin
      m_stage[k] = 16'h0;
      m_mask[k]  = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] slot, input logic [15:0] imm);
    instr_in       = {op, slot, imm, 8'($urandom)};
    instr_valid_in = 1'b1;
    #1;
    chk("accept_ready", instr_ready_out, 1'b1);
    chk("accept_idle", idle_out, 1'b1);
    step();
    instr_valid_in = 1'b0;
    instr_in       = $urandom;
  endtask

  task automatic do_setaddr(input int a);
    issue(4'b1000, 4'($urandom), 16'(a));
    if (a >= DEPTH) m_err[2] = 1'b1;
    else            m_addr   = a;
    #1;
    chk("setaddr_err", error_out, m_err);
    chk("setaddr_ready", instr_ready_out, 1'b1);
  endtask

  task automatic do_ldimm(input int slot, input logic [15:0] val);
    issue(4'b1001, 4'(slot), val);
    if (slot >= W) m_err[1] = 1'b1;
    else begin
      m_stage[slot] = val;
      m_mask[slot]  = 1'b1;
    end
    #1;
    chk("ldimm_err", error_out, m_err);
    chk("ldimm_ready", instr_ready_out, 1'b1);
  endtask

  task automatic do_illegal(input logic [3:0] op);
    issue(op, 4'($urandom), 16'($urandom));
    m_err[0] = 1'b1;
    #1;
    chk("illegal_err", error_out, m_err);
  endtask

  task automatic do_commit();
    issue(4'b1011, 4'($urandom), 16'($urandom));
    if (model_full()) begin
      m_mem[m_addr]     = model_line();
      m_written[m_addr] = 1'b1;
      for (int k = 0; k < W; k++) m_mask[k] = 1'b0;
      #1;
      chk("commit_busy", instr_ready_out, 1'b0);
      step();
      model_advance();
      #1;
      chk("commit_ready_back", instr_ready_out, 1'b1);
    end else begin
      m_err[1] = 1'b1;
      #1;
      chk("commit_refused_ready", instr_ready_out, 1'b1);
    end
    chk("commit_err", error_out, m_err);
  endtask

  task automatic do_ldbuf(input logic [LW-1:0] line, input int delay);
    issue(4'b1010, 4'($urandom), 16'($urandom));
    for (int i = 0; i < delay; i++) begin
      buffer_valid_in = 1'b0;
      buffer_read_in  = {$urandom, $urandom, $urandom};
      #1;
      chk("bufwait_no_ack", buffer_ack_out, 1'b0);
      chk("bufwait_busy", instr_ready_out, 1'b0);
      step();
    end
    buffer_read_in  = line;
    buffer_valid_in = 1'b1;
    #1;
    chk("buf_ack_pulse", buffer_ack_out, 1'b1);
    step();
    buffer_valid_in = 1'b0;
    buffer_read_in  = {$urandom, $urandom, $urandom};
    #1;
    chk("buf_ack_single", buffer_ack_out, 1'b0);
    chk("buf_write_busy", instr_ready_out, 1'b0);
    step();
    m_mem[m_addr]     = line;
    m_written[m_addr] = 1'b1;
    model_advance();
    #1;
    chk("buf_ready_back", instr_ready_out, 1'b1);
  endtask

  task automatic do_read(input int stall);
    logic [LW-1:0] exp;
    exp = m_mem[m_addr];
    issue(4'b1100, 4'($urandom), 16'($urandom));
    #1;
    chk("rd_c1_valid", abc_valid_out, 1'b0);
    chk("rd_c1_busy", instr_ready_out, 1'b0);
    step();
    #1;
    chk("rd_c2_valid", abc_valid_out, 1'b0);
    step();
    for (int i = 0; i < stall; i++) begin
      abc_ready_in = 1'b0;
      #1;
      chk("rd_hold_valid", abc_valid_out, 1'b1);
      chk("rd_hold_data", abc_out, exp);
      chk("rd_hold_busy", instr_ready_out, 1'b0);
      step();
    end
    abc_ready_in = 1'b1;
    #1;
    chk("rd_out_valid", abc_valid_out, 1'b1);
    chk("rd_out_data", abc_out, exp);
    step();
    abc_ready_in = 1'b0;
    m_abc = exp;
    model_advance();
    #1;
    chk("rd_after_valid", abc_valid_out, 1'b0);
    chk("rd_after_ready", instr_ready_out, 1'b1);
    chk("rd_after_data", abc_out, m_abc);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    #1;
    chk("rst_valid", abc_valid_out, 1'b0);
    chk("rst_idle", idle_out, 1'b1);
    step();
    step();
    rst_n_in = 1'b1;
    model_reset();
    #1;
    chk("rst_err", error_out, 3'b000);
    chk("rst_abc", abc_out, '0);
    chk("rst_ack", buffer_ack_out, 1'b0);
    chk("rst_ready", instr_ready_out, 1'b1);
  endtask

  task automatic fill_stage();
    for (int k = 0; k < W; k++) do_ldimm(k, 16'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] old_line;
    logic [LW-1:0] a5_line;
    int r;

    rst_n_in        = 1'b0;
    instr_in        = '0;
    instr_valid_in  = 1'b0;
    buffer_read_in  = '0;
    buffer_valid_in = 1'b0;
    abc_ready_in    = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
    model_reset();
    step();
    step();
    rst_n_in = 1'b1;
    #1;
    chk("reset_ready", instr_ready_out, 1'b1);
    chk("reset_idle", idle_out, 1'b1);
    chk("reset_abc", abc_out, '0);
    chk("reset_valid", abc_valid_out, 1'b0);
    chk("reset_ack", buffer_ack_out, 1'b0);
    chk("reset_err", error_out, 3'b000);

    // Staged line write then read back.
    do_setaddr(5);
    for (int k = 0; k < W; k++) do_ldimm(k, 16'((k + 1) * 16'h1111));
    do_commit();
    do_setaddr(5);
    do_read(0);
    chk("plan_line_const", abc_out, 96'h111122223333444455556666);

    // Incomplete commit refused.
    old_line = m_mem[5];
    for (int k = 0; k < 5; k++) do_ldimm(k, 16'h0BAD);
    do_commit();
    chk("partial_commit_err", error_out, 3'b010);
    do_setaddr(5);
    do_read(0);
    chk("partial_commit_old", abc_out, old_line);

    // Buffer line with a delayed valid, then a stalled read.
    a5_line = {12{8'hA5}};
    do_setaddr(7);
    do_ldbuf(a5_line, 4);
    do_setaddr(7);
    do_read(5);
    chk("ldbuf_line_const", abc_out, a5_line);

    // Error flags; addr must survive the bad SETADDR.
    do_reset();
    do_setaddr(7);
    do_illegal(4'hF);
    do_ldimm(9, 16'h1234);
    do_setaddr(400);
    chk("all_err_const", error_out, 3'b111);
    do_read(1);
    chk("bad_setaddr_keeps_addr", abc_out, a5_line);
    do_reset();

`ifdef FMA_LINE_MEMORY_AUTO_INCR_EN
    do_setaddr(374);
    fill_stage();
    do_commit();
    fill_stage();
    do_commit();
    chk("wrap_addr_model", 32'(m_addr), 32'd1);
    do_setaddr(374);
    do_read(0);
    do_read(2);
`endif

    // Reset while the read is in RD2 abandons it.
    do_setaddr(5);
    issue(4'b1100, 4'h0, 16'h0);
    step();
    do_reset();
    step();
    #1;
    chk("rd2_reset_valid", abc_valid_out, 1'b0);
    chk("rd2_reset_idle", idle_out, 1'b1);

    // Random traffic, addresses kept small so reads hit written lines.
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: begin
          if ($urandom_range(0, 5) == 0) do_setaddr(DEPTH + $urandom_range(0, 2000));
          else                           do_setaddr($urandom_range(0, 15));
        end
        1, 2, 3: do_ldimm($urandom_range(0, 7), 16'($urandom));
        4: do_commit();
        5: do_ldbuf({$urandom, $urandom, $urandom}, $urandom_range(0, 3));
        6, 7: begin
          if (m_written[m_addr]) do_read($urandom_range(0, 3));
          else                   do_ldbuf({$urandom, $urandom, $urandom}, $urandom_range(0, 2));
        end
        8: begin
          if ($urandom_range(0, 1) == 0) do_illegal(4'($urandom_range(0, 7)));
          else                           do_illegal(4'($urandom_range(13, 15)));
        end
        default: begin
          fill_stage();
          do_commit();
        end
      endcase
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
